instr_mem_loader: RTL and testbench

//  Program loader: the write side of the instruction memory that the datapath's PC fetch port reads.

---
 rtl/instr_mem_loader_pkg.sv | 24 ++
 rtl/instr_mem_loader_if.sv | 35 +++
 rtl/instr_mem_loader_byte_assembler.sv | 62 ++++++
 rtl/instr_mem_loader.sv | 136 +++++++++++++
 tb/tb_instr_mem_loader.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_mem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
// Word layout is little-endian: byte 0 of a word lands in bits [7:0].
package rv_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } state_t;

    localparam int WORD_BYTES = 4;
    localparam int BYTE_W     = 8;
    localparam int WORD_W     = WORD_BYTES * BYTE_W;
    localparam int LANE_IDX_W = $clog2(WORD_BYTES);

    // Byte address of a word slot; wraps modulo 2**32 by construction.
    function automatic logic [31:0] wordByteAddr(input logic [31:0] base,
                                                 input logic [31:0] wordIdx);
        return base + (wordIdx << 2);
    endfunction

endpackage

// File: rtl/instr_mem_loader_if.sv
// Byte-stream, instruction-memory write and status signals of the program loader.
// The loader owns the slave modport; whoever feeds the program owns the master modport.
interface instr_mem_loader_if #(
    parameter int ADDR_W = 8
);
    import rv_loader_pkg::*;

    logic              start;
    logic              byteValid;
    logic [BYTE_W-1:0] byteData;
    logic              lastByte;
    logic              byteReady;
    logic              imemWe;
    logic [31:0]       imemAddr;
    logic [WORD_W-1:0] imemWData;
    logic              coreResetN;
    logic              busy;
    logic              done;
    logic              errPartial;
    logic              errOverflow;
    logic [ADDR_W:0]   wordCount;

    modport master (
        output start, byteValid, byteData, lastByte,
        input  byteReady, imemWe, imemAddr, imemWData, coreResetN,
               busy, done, errPartial, errOverflow, wordCount
    );

    modport slave (
        input  start, byteValid, byteData, lastByte,
        output byteReady, imemWe, imemAddr, imemWData, coreResetN,
               busy, done, errPartial, errOverflow, wordCount
    );

endinterface

// File: rtl/instr_mem_loader_byte_assembler.sv
// Steers accepted bytes into four lanes of a 32-bit word and flags when the word is complete.
// A lastByte before lane 3 zero-pads the remaining upper lanes.
module byte_assembler
    import rv_loader_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rstN,
    input  logic              i_clear,
    input  logic              i_accept,
    input  logic [BYTE_W-1:0] i_data,
    input  logic              i_last,
    output logic [WORD_W-1:0] o_nextWord,
    output logic              o_wordComplete,
    output logic              o_padded,
    output logic              o_wordFull
);

    localparam logic [LANE_IDX_W-1:0] LAST_LANE = LANE_IDX_W'(WORD_BYTES - 1);

    logic [WORD_W-1:0]     r_lanes;
    logic [LANE_IDX_W-1:0] r_byteIdx;
    logic                  r_wordFull;
    logic [WORD_W-1:0]     w_nextWord;
    logic                  w_complete;

    // Word as it will look once the byte on i_data is taken, including the pad.
    always_comb begin
        w_nextWord = r_lanes;
        for (int k = 0; k < WORD_BYTES; k++) begin
            if (k == int'(r_byteIdx)) begin
                w_nextWord[k*BYTE_W +: BYTE_W] = i_data;
            end else if (i_last && (k > int'(r_byteIdx))) begin
                w_nextWord[k*BYTE_W +: BYTE_W] = '0;
            end
        end
    end

    assign w_complete     = i_accept && ((r_byteIdx == LAST_LANE) || i_last);
    assign o_wordComplete = w_complete;
    assign o_padded       = i_accept && i_last && (r_byteIdx != LAST_LANE);
    assign o_nextWord     = w_nextWord;
    assign o_wordFull     = r_wordFull;

    always_ff @(posedge i_clk or negedge i_rstN) begin
        if (!i_rstN) begin
            r_lanes    <= '0;
            r_byteIdx  <= '0;
            r_wordFull <= 1'b0;
        end else if (i_clear) begin
            r_lanes    <= '0;
            r_byteIdx  <= '0;
            r_wordFull <= 1'b0;
        end else if (i_accept) begin
            r_lanes   <= w_nextWord;
            r_byteIdx <= r_byteIdx + LANE_IDX_W'(1);
            if (w_complete) begin
                r_wordFull <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Program loader: assembles a byte stream into words, writes them to instruction memory
// and keeps the datapath in reset until the last word of the program has been written.
module instr_mem_loader
    import rv_loader_pkg::*;
#(
    parameter int          ADDR_W    = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clockDP,
    input  logic              resetDP,
    instr_mem_loader_if.slave bus
);

    localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};

    state_t            r_state;
    logic              r_byteReady;
    logic              r_imemWe;
    logic [31:0]       r_imemAddr;
    logic [WORD_W-1:0] r_imemWData;
    logic              r_coreResetN;
    logic              r_busy;
    logic              r_done;
    logic              r_errPartial;
    logic              r_errOverflow;
    logic [ADDR_W:0]   r_wordCount;
    logic              r_wordLast;

    logic              w_startOk;
    logic              w_accept;
    logic              w_clear;
    logic              w_complete;
    logic              w_padded;
    logic              w_wordFull;
    logic [WORD_W-1:0] w_nextWord;
    logic [ADDR_W:0]   w_nextCount;

    assign w_startOk   = bus.start && ((r_state == IDLE) || (r_state == DONE) || (r_state == ERROR));
    assign w_accept    = bus.byteValid && r_byteReady && !w_wordFull;
    assign w_clear     = w_startOk || (r_state == WRITE);
    assign w_nextCount = r_wordCount + {{ADDR_W{1'b0}}, 1'b1};

    byte_assembler u_assembler (
        .i_clk          (clockDP),
        .i_rstN         (resetDP),
        .i_clear        (w_clear),
        .i_accept       (w_accept),
        .i_data         (bus.byteData),
        .i_last         (bus.lastByte),
        .o_nextWord     (w_nextWord),
        .o_wordComplete (w_complete),
        .o_padded       (w_padded),
        .o_wordFull     (w_wordFull)
    );

    // Every output is registered here so the datapath sees glitch-free reset and strobes.
    always_ff @(posedge clockDP or negedge resetDP) begin
        if (!resetDP) begin
            r_state       <= IDLE;
            r_byteReady   <= 1'b0;
            r_imemWe      <= 1'b0;
            r_imemAddr    <= '0;
            r_imemWData   <= '0;
            r_coreResetN  <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_errPartial  <= 1'b0;
            r_errOverflow <= 1'b0;
            r_wordCount   <= '0;
            r_wordLast    <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE, ERROR: begin
                    if (bus.start) begin
                        r_state       <= LOAD;
                        r_byteReady   <= 1'b1;
                        r_busy        <= 1'b1;
                        r_done        <= 1'b0;
                        r_coreResetN  <= 1'b0;
                        r_errPartial  <= 1'b0;
                        r_errOverflow <= 1'b0;
                        r_wordCount   <= '0;
                        r_wordLast    <= 1'b0;
                    end
                end
                LOAD: begin
                    if (w_complete) begin
                        r_state     <= WRITE;
                        r_byteReady <= 1'b0;
                        r_imemWe    <= 1'b1;
                        r_imemAddr  <= wordByteAddr(BASE_ADDR, 32'(r_wordCount));
                        r_imemWData <= w_nextWord;
                        r_wordLast  <= bus.lastByte;
                        if (w_padded) begin
                            r_errPartial <= 1'b1;
                        end
                    end else if ((r_wordCount == CAP) && bus.byteValid) begin
                        // Memory is full and more program is offered: trap before wrapping.
                        r_state       <= ERROR;
                        r_byteReady   <= 1'b0;
                        r_busy        <= 1'b0;
                        r_errOverflow <= 1'b1;
                    end
                end
                WRITE: begin
                    r_imemWe    <= 1'b0;
                    r_wordCount <= w_nextCount;
                    if (r_wordLast) begin
                        r_state      <= DONE;
                        r_done       <= 1'b1;
                        r_coreResetN <= 1'b1;
                        r_busy       <= 1'b0;
                    end else begin
                        r_state     <= LOAD;
                        r_byteReady <= (w_nextCount != CAP);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.byteReady   = r_byteReady;
    assign bus.imemWe      = r_imemWe;
    assign bus.imemAddr    = r_imemAddr;
    assign bus.imemWData   = r_imemWData;
    assign bus.coreResetN  = r_coreResetN;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.errPartial  = r_errPartial;
    assign bus.errOverflow = r_errOverflow;
    assign bus.wordCount   = r_wordCount;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: a byte-level model predicts every memory write and
// the final status; a negedge monitor pops and compares each imemWe cycle.
module tb_instr_mem_loader;

    localparam int          ADDR_W    = 2;
    localparam logic [31:0] BASE      = 32'h0000_1000;
    localparam int          CAP_BYTES = 4 * (1 << ADDR_W);

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rstN;

    wr_t        expQ[$];
    logic [7:0] stimBytes[$];
    int         checks = 0;
    int         errors = 0;
    int         expWordCount;
    bit         expDone;
    bit         expPartial;
    bit         expOverflow;

    instr_mem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    instr_mem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
        .clockDP (clk),
        .resetDP (rstN),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: each write strobe must match the oldest predicted write.
    always @(negedge clk) begin
        wr_t e;
        if (rstN === 1'b1 && bus.imemWe === 1'b1) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedWrite: got addr 0x%0h data 0x%0h, expected no write",
                         bus.imemAddr, bus.imemWData);
            end else begin
                e = expQ.pop_front();
                checkOutput("imemWrite", {bus.imemAddr, bus.imemWData}, e);
            end
        end
    end

    // Reference model: byte i lands in word i/4, lane i%4; bytes past capacity only overflow.
    task automatic modelLoad(input bit setLast);
        int n;
        int nAcc;
        int nWords;
        logic [31:0] data;
        n      = stimBytes.size();
        nAcc   = (n > CAP_BYTES) ? CAP_BYTES : n;
        nWords = setLast ? (nAcc + 3) / 4 : nAcc / 4;
        for (int w = 0; w < nWords; w++) begin
            data = '0;
            for (int k = 0; k < 4; k++) begin
                if (w * 4 + k < nAcc) begin
                    data = data | (32'(stimBytes[w*4+k]) << (8 * k));
                end
            end
            expQ.push_back('{addr: BASE + 32'(4 * w), data: data});
        end
        expWordCount = nWords;
        expOverflow  = (n > CAP_BYTES);
        expDone      = setLast && !expOverflow;
        expPartial   = expDone && (n % 4 != 0);
    endtask

    task automatic doStart(input bit offerByte);
        @(negedge clk);
        bus.start = 1'b1;
        if (offerByte) begin
            bus.byteValid = 1'b1;
            bus.byteData  = 8'hEE;
            bus.lastByte  = 1'b1;
        end
        @(negedge clk);
        bus.start     = 1'b0;
        bus.byteValid = 1'b0;
        bus.lastByte  = 1'b0;
    endtask

    // Sends stimBytes[0..nSend-1]; called and returns on a negedge.
    task automatic applyStimulus(input int nSend, input bit setLast, input int gapPct, input bit startNoise);
        bit ready;
        bit accepted;
        for (int i = 0; i < nSend; i++) begin
            while (int'($urandom_range(99)) < gapPct) begin
                bus.byteValid = 1'b0;
                @(negedge clk);
            end
            bus.byteValid = 1'b1;
            bus.byteData  = stimBytes[i];
            bus.lastByte  = setLast && (i == nSend - 1);
            bus.start     = startNoise && (i != nSend - 1) && ($urandom_range(3) == 0);
            accepted = 1'b0;
            for (int c = 0; c < 50 && !accepted; c++) begin
                ready = bus.byteReady;
                @(posedge clk);
                if (ready) accepted = 1'b1;
                @(negedge clk);
                bus.start = 1'b0;
            end
            if (!accepted) begin
                checks++;
                errors++;
                $display("[TB] FAIL byteHandshake: byte %0d not accepted, expected acceptance within 50 cycles", i);
                break;
            end
        end
        bus.byteValid = 1'b0;
        bus.lastByte  = 1'b0;
        bus.start     = 1'b0;
    endtask

    task automatic waitSettled();
        for (int c = 0; c < 30; c++) begin
            if (!bus.busy) break;
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic checkStatus(input string tag);
        checkOutput({tag, ".done"},        64'(bus.done),        64'(expDone));
        checkOutput({tag, ".coreResetN"},  64'(bus.coreResetN),  64'(expDone));
        checkOutput({tag, ".busy"},        64'(bus.busy),        64'(0));
        checkOutput({tag, ".wordCount"},   64'(bus.wordCount),   64'(expWordCount));
        checkOutput({tag, ".errPartial"},  64'(bus.errPartial),  64'(expPartial));
        checkOutput({tag, ".errOverflow"}, 64'(bus.errOverflow), 64'(expOverflow));
        checkOutput({tag, ".pendingWrites"}, 64'(expQ.size()), 64'(0));
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".ctrl"},
                    64'({bus.byteReady, bus.imemWe, bus.coreResetN, bus.busy, bus.done,
                         bus.errPartial, bus.errOverflow, bus.wordCount}), 64'(0));
        checkOutput({tag, ".addrData"}, {bus.imemAddr, bus.imemWData}, 64'(0));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        rstN          = 1'b0;
        bus.start     = 1'b0;
        bus.byteValid = 1'b0;
        bus.byteData  = 8'h00;
        bus.lastByte  = 1'b0;

        // Test 1: reset and idle
        #2;
        checkAllZero("inReset");
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checkAllZero("idle");
        end

        // Test 2: two instructions; a byte offered together with start must be ignored
        stimBytes = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h00};
        modelLoad(1'b1);
        doStart(1'b1);
        applyStimulus(stimBytes.size(), 1'b1, 0, 1'b0);
        waitSettled();
        checkStatus("twoWords");

        // Test 3: random bytes, random valid gaps, start pulses during LOAD/WRITE
        for (int r = 0; r < 3; r++) begin
            n = int'($urandom_range(5, CAP_BYTES));
            stimBytes.delete();
            for (int i = 0; i < n; i++) stimBytes.push_back(8'($urandom));
            modelLoad(1'b1);
            doStart(1'b0);
            applyStimulus(n, 1'b1, 40, 1'b1);
            waitSettled();
            checkStatus("random");
        end

        // Test 4: five bytes, partial last word
        stimBytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        modelLoad(1'b1);
        doStart(1'b0);
        applyStimulus(5, 1'b1, 0, 1'b0);
        waitSettled();
        checkStatus("partial");

        // Test 5: fill memory, then offer one more byte
        stimBytes.delete();
        for (int i = 0; i <= CAP_BYTES; i++) stimBytes.push_back(8'($urandom));
        modelLoad(1'b0);
        doStart(1'b0);
        applyStimulus(CAP_BYTES, 1'b0, 20, 1'b0);
        bus.byteValid = 1'b1;
        bus.byteData  = stimBytes[CAP_BYTES];
        for (int c = 0; c < 20; c++) begin
            if (bus.errOverflow) break;
            @(negedge clk);
        end
        bus.byteValid = 1'b0;
        @(negedge clk);
        checkStatus("overflow");
        doStart(1'b0);
        checkOutput("restart.wordCount",   64'(bus.wordCount),   64'(0));
        checkOutput("restart.busy",        64'(bus.busy),        64'(1));
        checkOutput("restart.errOverflow", 64'(bus.errOverflow), 64'(0));
        checkOutput("restart.coreResetN",  64'(bus.coreResetN),  64'(0));

        // Test 6: reset after six bytes, then a fresh one-word load
        stimBytes.delete();
        for (int i = 0; i < 6; i++) stimBytes.push_back(8'($urandom));
        modelLoad(1'b0);
        applyStimulus(6, 1'b0, 0, 1'b0);
        rstN = 1'b0;
        #1;
        checkAllZero("midReset");
        checkOutput("midReset.pendingWrites", 64'(expQ.size()), 64'(0));
        @(negedge clk);
        rstN = 1'b1;
        stimBytes = '{8'h37, 8'h01, 8'h00, 8'h80};
        modelLoad(1'b1);
        doStart(1'b0);
        applyStimulus(4, 1'b1, 0, 1'b0);
        waitSettled();
        checkStatus("afterReset");

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
